vec_argmax_stage: RTL
=====================

Name: vec_argmax_stage

Overview:
- Downstream classifier stage for the final fully connected layer. Sits directly on that layer's output_valid/output_ready/output_data stream.
- Consumes one M-element signed output vector per inference and produces the index and value of the maximum element.
- Accumulation of the next vector overlaps with holding the previous result, so back-to-back vectors do not stall unless the result is not drained in time.

Parameters:
- M, 6, elements per vector (must equal the producing layer's M); M >= 2.
- T, 20, element width in bits, two's complement.
- Derived localparam IDX_W = $clog2(M), width of the index and element counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- input_valid  input  1  upstream element valid.
- input_ready  output  1  stage can accept an element this cycle.
- input_data  input  T  signed element.
- output_valid  output  1  result held in output registers.
- output_ready  input  1  downstream accepts the result.
- out_index  output  IDX_W  position (0..M-1) of the maximum element.
- out_value  output  T  signed maximum value.

Behaviour:
- Transfers:
  - Input beat transfers when input_valid && input_ready at a clk edge.
  - Output transfers when output_valid && output_ready at a clk edge.
- Reset (reset == 0, asynchronous):
  - count = 0, cur_max = 0, cur_idx = 0.
  - output_valid = 0, out_index = 0, out_value = 0.
  - input_ready is 1 after reset.
- Accumulation registers are separate from the output registers:
  - count is the element position, 0..M-1.
  - cur_max is the running maximum, T bits signed.
  - cur_idx is the index of cur_max.
- On an accepted beat:
  - count == 0: cur_max <= input_data, cur_idx <= 0.
  - count > 0: if input_data > cur_max (signed, strictly greater), then cur_max <= input_data and cur_idx <= count. Ties keep the lower index.
  - count increments. At count == M-1 it wraps to 0.
- Completion (accepted beat with count == M-1):
  - out_value <= final max including this beat. out_index <= its index.
  - output_valid <= 1 next cycle, so latency from the last input beat to output_valid is 1 cycle.
  - The final element is compared combinationally with cur_max in the same cycle.
- Result hold:
  - output_valid, out_index and out_value stay stable until the output transfer.
  - output_valid deasserts the cycle after the transfer unless a new completion happens at the same edge.
  - Simultaneous output transfer and new completion: the output registers load the new result and output_valid stays 1.
- input_ready = !(output_valid && count == M-1 && !output_ready).
  - The stage stalls only on the final element of a vector while the previous result is undrained and not being taken.
  - This is a combinational path from output_ready; no path from input_valid to input_ready.
- input_data is ignored when input_valid = 0. No state changes without a transfer.
- Reset mid-vector discards the partial vector and any held result. The next accepted beat is element 0.
- Arithmetic:
  - Comparisons are full T-bit signed.
  - No truncation or saturation; out_value is the exact input element.
  - Most negative value (-2^(T-1)) is handled correctly.

Test Plan:
- Reset then vector -147, 357, -143, -75, 76, -511 with output_ready=1 -> output_valid=1 exactly 1 cycle after last beat; out_index=1, out_value=357; output_valid=0 the following cycle.
- Ties and all-negative: vector -5, -3, -3, -524288, -3, -9 -> out_index=1, out_value=-3.
- Backpressure: output_ready=0; send vector A (max 490 at index 3), then 5 elements of vector B -> input_ready drops on B's 6th element only. Raise output_ready -> A transfers. B completes, and its result appears with output_valid held continuously high.
- Back-to-back with output_ready=1 and input_valid constantly high for 3 vectors (18 beats) -> input_ready never drops; 3 results each 1 cycle after their last beat, correct indices.
- Max at last position: vector 0, 1, 2, 3, 4, 524287 -> out_index=5, out_value=524287. Gapped input_valid (toggling) gives the same result.
- Asynchronous reset asserted mid-clock after 3 beats -> outputs and count clear immediately. Then a fresh vector 7, 0, 0, 0, 0, 0 gives out_index=0, out_value=7.

Source files
------------

// File: rtl/vec_argmax_stage_if.sv
// Stream bundle between the final fully connected layer, the argmax stage
// and the downstream consumer of the classification result.
interface vec_argmax_stage_if #(
  parameter int M = 6,
  parameter int T = 20
) ();
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

  logic                    input_valid;
  logic                    input_ready;
  logic signed [T-1:0]     input_data;
  logic                    output_valid;
  logic                    output_ready;
  logic        [IDX_W-1:0] out_index;
  logic signed [T-1:0]     out_value;

  // Drives elements in and accepts results.
  modport master (
    output input_valid,
    output input_data,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  out_index,
    input  out_value
  );

  // The argmax stage itself.
  modport slave (
    input  input_valid,
    input  input_data,
    input  output_ready,
    output input_ready,
    output output_valid,
    output out_index,
    output out_value
  );
endinterface

// File: rtl/vec_argmax_stage.sv
// Streaming argmax over M-element signed vectors: a running max is accumulated
// while the previous result waits in separate output registers.
module vec_argmax_stage #(
  parameter int M = 6,
  parameter int T = 20
) (
  input  logic               clk,
  input  logic               reset,
  vec_argmax_stage_if.slave  bus
);
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

  logic        [IDX_W-1:0] count_q,     count_d;
  logic signed [T-1:0]     cur_max_q,   cur_max_d;
  logic        [IDX_W-1:0] cur_idx_q,   cur_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic        [IDX_W-1:0] out_index_q, out_index_d;
  logic signed [T-1:0]     out_value_q, out_value_d;

  logic                    last_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    out_xfer_s;
  logic                    beat_gt_s;
  logic signed [T-1:0]     cand_max_s;
  logic        [IDX_W-1:0] cand_idx_s;

  // Handshake decode; input_ready depends on output_ready but never on input_valid.
  always_comb begin
    last_s     = (count_q == LAST_IDX);
    ready_s    = !(out_valid_q && last_s && !bus.output_ready);
    accept_s   = bus.input_valid && ready_s;
    out_xfer_s = out_valid_q && bus.output_ready;
  end

  // Running max including the current beat; strict compare keeps the lower index on ties.
  always_comb begin
    beat_gt_s  = (bus.input_data > cur_max_q);
    cand_max_s = cur_max_q;
    cand_idx_s = cur_idx_q;
    if (count_q == IDX_W'(0)) begin
      cand_max_s = bus.input_data;
      cand_idx_s = IDX_W'(0);
    end else if (beat_gt_s) begin
      cand_max_s = bus.input_data;
      cand_idx_s = count_q;
    end else begin
      cand_max_s = cur_max_q;
      cand_idx_s = cur_idx_q;
    end
  end

  // Accumulator next state: only an accepted beat moves it.
  always_comb begin
    count_d   = count_q;
    cur_max_d = cur_max_q;
    cur_idx_d = cur_idx_q;
    if (accept_s) begin
      cur_max_d = cand_max_s;
      cur_idx_d = cand_idx_s;
      if (last_s) begin
        count_d = IDX_W'(0);
      end else begin
        count_d = count_q + IDX_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Result registers: a completion wins over a drain landing on the same edge.
  always_comb begin
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_value_d = out_value_q;
    if (accept_s && last_s) begin
      out_valid_d = 1'b1;
      out_index_d = cand_idx_s;
      out_value_d = cand_max_s;
    end else if (out_xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Accumulator state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      cur_max_q <= '0;
      cur_idx_q <= '0;
    end else begin
      count_q   <= count_d;
      cur_max_q <= cur_max_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  // Output result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_value_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_value_q <= out_value_d;
    end
  end

  assign bus.input_ready  = ready_s;
  assign bus.output_valid = out_valid_q;
  assign bus.out_index    = out_index_q;
  assign bus.out_value    = out_value_q;
endmodule
